reg_bank_arbiter: RTL and testbench
===================================

# reg_bank_arbiter

Round-robin write arbiter and sequencer for the shared bank of 12-bit enable registers in the ML datapath (weights, biases, activation staging). Up to NREQ requesters each present an address/data pair under a valid/ready handshake. The block grants one requester at a time and drives exactly one register's enable together with the shared data bus for one cycle. Out-of-range addresses are flagged and never written.

## Interface
- NREQ, 4: number of requesters.
- WIDTH, 12: register data width.
- DEPTH, 8: number of registers in the bank.
- AW, 3: address width, equal to clog2(DEPTH).
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-low; rst=0 clears all state immediately.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_addr  in  NREQ*AW  target register per requester; requester i occupies slice [i*AW +: AW].
- req_data  in  NREQ*WIDTH  write data per requester; requester i occupies slice [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot; the handshake completes on the edge where valid and ready are both 1.
- reg_en  out  DEPTH  one-hot write enable to the register bank.
- reg_d  out  WIDTH  data to the register bank.
- grant_id  out  clog2(NREQ)  index of the current or last granted requester.
- busy  out  1  high while the FSM is not in IDLE.
- addr_err  out  1  one-cycle pulse when a granted address is DEPTH or greater.

## Operation
- FSM states: IDLE, GRANT, ISSUE.
- IDLE:
  - If any req_valid is 1, the rr_arbiter picks the winner, starting the search at ptr. The winner is registered into grant_id, and the FSM moves to GRANT.
  - Otherwise the FSM stays in IDLE.
- GRANT:
  - req_ready[grant_id]=1; all other ready bits are 0.
  - At the edge, the selected addr and data are latched and the FSM moves to ISSUE.
  - ptr becomes grant_id+1, modulo NREQ.
- ISSUE:
  - reg_en and reg_d are driven from the latched values; reg_d holds the latched data for the whole cycle.
  - If any req_valid is 1, the FSM arbitrates and goes directly to GRANT. Otherwise it returns to IDLE.
- Requesters hold valid, addr and data stable until their handshake. Deasserting valid before ready is legal: the request is withdrawn. If the granted requester's valid is 0 in GRANT, no handshake occurs, nothing is latched, and the FSM returns to IDLE.
- An address of DEPTH or greater that is latched in GRANT produces reg_en=0 in ISSUE and addr_err=1. The handshake still completes.
- At most one reg_en bit is high in any cycle.
- Simultaneous requests are served in strict rotation from ptr. With all NREQ requesters valid, each receives one grant per NREQ grants.

## Timing
- Reset values: state=IDLE, ptr=0, grant_id=0, req_ready=0, reg_en=0, reg_d=0, busy=0, addr_err=0.
- Latency from req_valid rising in IDLE:
  - req_ready is high in cycle +1.
  - reg_en is high in cycle +2.
  - The register captures the data at the end of cycle +2.
- Sustained throughput is one write per 2 cycles.
- rst falling mid-operation clears reg_en and req_ready immediately. A write in ISSUE is lost, and its requester is not notified.
- reg_en, reg_d and addr_err are registered outputs. req_ready is decoded from state and grant_id.

## Configuration
- REG_BANK_ARB_LOCK_EN defined:
  - Adds input req_lock (NREQ bits).
  - If req_lock[grant_id] is 1 at the GRANT edge, ptr is not advanced. A still-valid locked requester therefore wins the next arbitration, which supports burst weight loads.
- REG_BANK_ARB_LOCK_EN undefined: the req_lock port is absent and arbitration is pure round-robin.

## Structure
- Package reg_bank_pkg holds:
  - the state enum (IDLE, GRANT, ISSUE);
  - default constants WIDTH=12, DEPTH=8, NREQ=4.
- Sub-module rr_arbiter (combinational):
  - Inputs: req vector and ptr.
  - Outputs: winner index and any_req.
- The top level holds the FSM, ptr, the latches and the output registers.

## Test plan
- Reset then idle: rst=0, then rst=1 with no valids. All outputs stay 0 and busy stays 0 for 10 cycles.
- Single write: req_valid[0]=1, addr=3, data=12'h345.
  - req_ready[0]=1 at cycle +1.
  - reg_en=8'b0000_1000 with reg_d=12'h345 at cycle +2.
- Contention: all four requesters valid, data 12'h04a, 12'h111, 12'h400, 12'h876 to addresses 0-3. Grants occur in order 0,1,2,3, one ISSUE every 2 cycles, and ptr wraps back to 0.
- Bad address: DEPTH=6 with addr=7 and data=12'habc. The handshake completes, addr_err pulses once, and reg_en stays 0.
- Reset mid-operation: assert rst=0 during ISSUE. reg_en drops within the same cycle, and after release the FSM is in IDLE with ptr=0.
- Lock (with REG_BANK_ARB_LOCK_EN): requesters 1 and 2 valid with req_lock[1]=1. Requester 1 receives 3 consecutive grants, then requester 2 is granted after lock[1] deasserts.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared state type and default sizes for reg_bank_arbiter
package reg_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 12;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_NREQ  = 4;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_arbiter.sv
// rtl/reg_bank_arbiter_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            any_req
);

  logic [IW-1:0] w_idx;

  // Scan from the far end back towards ptr so the closest requester overwrites last.
  always_comb begin
    winner  = ptr;
    any_req = |req;
    w_idx   = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = IW'((int'(ptr) + k) % NREQ);
      if (req[w_idx]) begin
        winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - round-robin write sequencer for the enable-register bank
// Optional REG_BANK_ARB_LOCK_EN adds req_lock to hold ptr on a locked grantee.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int IW    = idx_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
`ifdef REG_BANK_ARB_LOCK_EN
  input  logic [NREQ-1:0]       req_lock,
`endif
  output logic [NREQ-1:0]       req_ready,
  output logic [DEPTH-1:0]      reg_en,
  output logic [WIDTH-1:0]      reg_d,
  output logic [IW-1:0]         grant_id,
  output logic                  busy,
  output logic                  addr_err
);

  localparam logic [DEPTH-1:0] EN_ONE = DEPTH'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_grant_id;
  logic [IW-1:0]    w_winner;
  logic [IW-1:0]    w_ptr_adv;
  logic             w_any;
  logic             w_load_grant;
  logic             w_accept;
  logic             w_hold_ptr;
  logic             w_sel_oob;
  logic [AW-1:0]    w_sel_addr;
  logic [WIDTH-1:0] w_sel_data;
  logic [DEPTH-1:0] r_reg_en;
  logic [WIDTH-1:0] r_reg_d;
  logic             r_addr_err;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req     (req_valid),
    .ptr     (r_ptr),
    .winner  (w_winner),
    .any_req (w_any)
  );

  assign w_sel_addr = req_addr[int'(r_grant_id)*AW +: AW];
  assign w_sel_data = req_data[int'(r_grant_id)*WIDTH +: WIDTH];
  assign w_sel_oob  = int'(w_sel_addr) >= DEPTH;
  assign w_ptr_adv  = (int'(r_grant_id) == NREQ - 1) ? '0 : r_grant_id + IW'(1);

`ifdef REG_BANK_ARB_LOCK_EN
  assign w_hold_ptr = req_lock[r_grant_id];
`else
  assign w_hold_ptr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load_grant = 1'b0;
    w_accept     = 1'b0;
    req_ready    = '0;
    busy         = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_load_grant = 1'b1;
          w_state_nxt  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        req_ready[r_grant_id] = 1'b1;
        // A withdrawn request falls back to IDLE without touching ptr.
        if (req_valid[r_grant_id]) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (w_any) begin
          w_load_grant = 1'b1;
          w_state_nxt  = ST_GRANT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_reg_en   <= '0;
      r_reg_d    <= '0;
      r_addr_err <= 1'b0;
    end else begin
      if (w_load_grant) begin
        r_grant_id <= w_winner;
      end
      if (w_accept) begin
        r_ptr      <= w_hold_ptr ? r_ptr : w_ptr_adv;
        r_reg_en   <= w_sel_oob ? '0 : (EN_ONE << w_sel_addr);
        r_reg_d    <= w_sel_data;
        r_addr_err <= w_sel_oob;
      end else begin
        r_reg_en   <= '0;
        r_addr_err <= 1'b0;
      end
    end
  end

  assign reg_en   = r_reg_en;
  assign reg_d    = r_reg_d;
  assign addr_err = r_addr_err;
  assign grant_id = r_grant_id;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - directed and random checks of reg_bank_arbiter against a transaction model
module tb_reg_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 12;
  localparam int DEPTH = 6;
  localparam int AW    = 3;
  localparam int IW    = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [DEPTH-1:0]      reg_en;
  logic [WIDTH-1:0]      reg_d;
  logic [IW-1:0]         grant_id;
  logic                  busy;
  logic                  addr_err;
`ifdef REG_BANK_ARB_LOCK_EN
  logic [NREQ-1:0]       req_lock;
`endif

  always #5 clk = ~clk;

  reg_bank_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
`ifdef REG_BANK_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .reg_en    (reg_en),
    .reg_d     (reg_d),
    .grant_id  (grant_id),
    .busy      (busy),
    .addr_err  (addr_err)
  );

  int vectors = 0;
  int fails   = 0;

  // Requester-side view of pending writes.
  logic [NREQ-1:0] val_v;
  logic [NREQ-1:0] lock_v;
  int adr [NREQ];
  int dat [NREQ];

  // Expected observable values for the cycle about to be sampled.
  int               m_ptr;
  int               m_gid;
  logic [NREQ-1:0]  m_ready;
  logic [DEPTH-1:0] m_en;
  logic [WIDTH-1:0] m_d;
  logic             m_err;

  int          cyc;
  int          last_hs;
  int          hs_count;
  int          first_hs_cyc;
  int          last_hs_cyc;
  logic [31:0] ord;
  int          cnt1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]               = val_v[i];
      req_addr[i*AW +: AW]       = AW'(adr[i]);
      req_data[i*WIDTH +: WIDTH] = WIDTH'(dat[i]);
    end
`ifdef REG_BANK_ARB_LOCK_EN
    req_lock = lock_v;
`endif
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_gid   = 0;
    m_ready = '0;
    m_en    = '0;
    m_d     = '0;
    m_err   = 1'b0;
    val_v   = '0;
    lock_v  = '0;
    for (int i = 0; i < NREQ; i++) begin
      adr[i] = 0;
      dat[i] = 0;
    end
  endtask

  task automatic clr_log();
    hs_count     = 0;
    first_hs_cyc = 0;
    last_hs_cyc  = 0;
    ord          = '0;
    last_hs      = -1;
  endtask

  // One clock: check outputs at the falling edge, then advance the model:
  // a grant cycle is followed by a write cycle; every other cycle arbitrates.
  task automatic cycle();
    logic [NREQ-1:0]  n_ready;
    logic [DEPTH-1:0] n_en;
    logic             n_err;
    logic             found;
    int               hs;
    int               idx;
    apply();
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(m_ready));
    chk("reg_en", 32'(reg_en), 32'(m_en));
    chk("reg_d", 32'(reg_d), 32'(m_d));
    chk("addr_err", 32'(addr_err), 32'(m_err));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("busy", 32'(busy), 32'((m_ready != 0) || (m_en != 0) || m_err));
    chk("reg_en_onehot0", 32'($onehot0(reg_en)), 32'(1));
    hs      = -1;
    n_ready = '0;
    n_en    = '0;
    n_err   = 1'b0;
    found   = 1'b0;
    if (m_ready != 0) begin
      if (val_v[m_gid]) begin
        hs = m_gid;
        if (adr[m_gid] < DEPTH) n_en = DEPTH'(1) << adr[m_gid];
        else n_err = 1'b1;
        m_d = WIDTH'(dat[m_gid]);
        if (!lock_v[m_gid]) m_ptr = (m_gid + 1) % NREQ;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (!found && val_v[idx]) begin
          found = 1'b1;
          m_gid = idx;
        end
      end
      if (found) n_ready = NREQ'(1) << m_gid;
    end
    m_ready = n_ready;
    m_en    = n_en;
    m_err   = n_err;
    last_hs = hs;
    if (hs >= 0) begin
      ord = {ord[27:0], 4'(hs)};
      if (hs_count == 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
      hs_count++;
    end
    cyc++;
    @(posedge clk);
    #1;
    if (hs >= 0) val_v[hs] = 1'b0;
  endtask

  initial begin
    cyc = 0;
    cnt1 = 0;
    model_reset();
    clr_log();
    apply();

    // Reset values while rst is held low, then ten idle cycles.
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_en", 32'(reg_en), 32'(0));
    chk("rst_d", 32'(reg_d), 32'(0));
    chk("rst_gid", 32'(grant_id), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_err", 32'(addr_err), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) cycle();

    // Contention: all four valid, served 0,1,2,3 one write every two cycles.
    clr_log();
    val_v = '1;
    adr[0] = 0; dat[0] = 'h04a;
    adr[1] = 1; dat[1] = 'h111;
    adr[2] = 2; dat[2] = 'h400;
    adr[3] = 3; dat[3] = 'h876;
    repeat (10) cycle();
    chk("contention_order", 32'(ord[15:0]), 32'h0123);
    chk("contention_count", 32'(hs_count), 32'(4));
    chk("contention_spacing", 32'(last_hs_cyc - first_hs_cyc), 32'(6));

    // ptr has wrapped: requester 0 beats requester 3.
    val_v[0] = 1'b1; adr[0] = 5; dat[0] = 'h0f0;
    val_v[3] = 1'b1; adr[3] = 4; dat[3] = 'h00f;
    cycle();
    cycle();
    chk("wrap_grant", 32'(grant_id), 32'(0));
    repeat (6) cycle();

    // Single write: ready at +1, enable and data at +2.
    val_v[0] = 1'b1; adr[0] = 3; dat[0] = 'h345;
    cycle();
    chk("single_ready", 32'(req_ready), 32'b0001);
    cycle();
    chk("single_en", 32'(reg_en), 32'b001000);
    chk("single_d", 32'(reg_d), 32'h345);
    cycle();
    chk("single_done_en", 32'(reg_en), 32'(0));
    repeat (2) cycle();

    // Out-of-range address: handshake completes, error pulses once, no enable.
    val_v[2] = 1'b1; adr[2] = 7; dat[2] = 'habc;
    cycle();
    chk("bad_ready", 32'(req_ready), 32'b0100);
    cycle();
    chk("bad_err", 32'(addr_err), 32'(1));
    chk("bad_en", 32'(reg_en), 32'(0));
    cycle();
    chk("bad_err_clear", 32'(addr_err), 32'(0));
    repeat (2) cycle();

    // Reset during ISSUE drops the write; ptr comes back at 0.
    val_v[1] = 1'b1; adr[1] = 2; dat[1] = 'h5a5;
    cycle();
    cycle();
    chk("mid_en_before", 32'(reg_en), 32'b000100);
    rst = 1'b0;
    #1;
    chk("mid_en_after", 32'(reg_en), 32'(0));
    chk("mid_ready_after", 32'(req_ready), 32'(0));
    chk("mid_busy_after", 32'(busy), 32'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle();
    val_v[1] = 1'b1; adr[1] = 1; dat[1] = 'h123;
    val_v[2] = 1'b1; adr[2] = 4; dat[2] = 'h456;
    cycle();
    cycle();
    chk("post_reset_grant", 32'(grant_id), 32'(1));
    repeat (6) cycle();

`ifdef REG_BANK_ARB_LOCK_EN
    // Locked requester 1 takes three grants in a row before requester 2.
    clr_log();
    cnt1 = 0;
    val_v[1] = 1'b1; adr[1] = 1; dat[1] = 'h101;
    val_v[2] = 1'b1; adr[2] = 2; dat[2] = 'h202;
    lock_v[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_hs == 1) begin
        cnt1++;
        if (cnt1 < 3) begin
          val_v[1] = 1'b1;
          dat[1]   = 'h101 + cnt1;
        end else begin
          lock_v[1] = 1'b0;
        end
      end
    end
    chk("lock_order", 32'(ord[15:0]), 32'h1112);
    chk("lock_count", 32'(hs_count), 32'(4));
`endif

    // Random traffic, addresses include out-of-range values.
    for (int n = 0; n < 500; n++) begin
      cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (!val_v[i] && ($urandom_range(0, 3) == 0)) begin
          val_v[i] = 1'b1;
          adr[i]   = int'($urandom_range(0, 7));
          dat[i]   = int'($urandom_range(0, 4095));
        end
      end
    end
    repeat (12) cycle();
    chk("drain_busy", 32'(busy), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
